// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES S-box tables, lookup function and engine state type
package des_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } des_state_e;

    // SBOX[k][row] packs the 16 columns of one row; column 0 is the most significant nibble.
    localparam logic [0:15][3:0] SBOX [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    function automatic logic [3:0] des_sbox(input logic [2:0] k, input logic [5:0] b);
        logic [1:0] row;
        logic [3:0] col;
        row = {b[5], b[0]};
        col = b[4:1];
        return SBOX[k][row][col];
    endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// rtl/des_sbox_lane.sv - one combinational S-box lookup lane
module des_sbox_lane (
    input  logic [2:0] box,
    input  logic [5:0] group,
    output logic [3:0] nibble
);
    import des_pkg::*;

    assign nibble = des_sbox(box, group);

endmodule

// File: rtl/des_sbox_sub_engine.sv
// rtl/des_sbox_sub_engine.sv - DES S-box substitution stage, LANES lookups per cycle
module des_sbox_sub_engine #(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);
    import des_pkg::*;

    localparam int         NSTEP     = (LANES > 0) ? 8 / LANES : 1;
    localparam logic [2:0] LAST_STEP = 3'(NSTEP - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_illegal
        $fatal(1, "des_sbox_sub_engine: LANES must be 1, 2, 4 or 8");
    end

    des_state_e  state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [47:0] in_q, in_d;
    logic [31:0] result_q, result_d;
    logic        accept;

    logic [5:0]  group       [8];
    logic [2:0]  lane_box    [LANES];
    logic [5:0]  lane_group  [LANES];
    logic [3:0]  lane_nibble [LANES];

    // Group 0 (S1) sits in the top six bits of the captured block.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            group[k] = in_q[47 - 6*k -: 6];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_box[j]   = 3'(int'(step_q) * LANES + j);
        assign lane_group[j] = group[lane_box[j]];

        des_sbox_lane u_lane (
            .box    (lane_box[j]),
            .group  (lane_group[j]),
            .nibble (lane_nibble[j])
        );
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_data  = result_q;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        in_d     = in_q;
        result_d = result_q;
        if (accept) begin
            // Covers both the IDLE accept and the back-to-back accept on DONE exit.
            state_d  = BUSY;
            step_d   = '0;
            in_d     = in_data;
            result_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                BUSY: begin
                    for (int k = 0; k < 8; k++) begin
                        for (int j = 0; j < LANES; j++) begin
                            if (lane_box[j] == 3'(k)) begin
                                result_d[4*(7-k) +: 4] = lane_nibble[j];
                            end
                        end
                    end
                    step_d = step_q + 3'd1;
                    if (step_q == LAST_STEP) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            in_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            in_q     <= in_d;
            result_q <= result_d;
        end
    end

endmodule
